// File: rtl/ipm_red_mask_seq_if.sv
// ipm_red_mask_seq_if: request, randomness and result bundle for the IPM masking sequencer
interface ipm_red_mask_seq_if #(parameter int v = 4);
  logic               start;
  logic [127:0]       plaintext;
  logic [8*v-1:0]     L1;
  logic [8*v-1:0]     L2;
  logic [8*(v-2)-1:0] rnd_in;
  logic               rnd_valid;
  logic               rnd_ready;
  logic               busy;
  logic               done;
  logic [128*v-1:0]   masked_plaintext;
  modport master (
    output start, plaintext, L1, L2, rnd_in, rnd_valid,
    input  rnd_ready, busy, done, masked_plaintext
  );
  modport slave (
    input  start, plaintext, L1, L2, rnd_in, rnd_valid,
    output rnd_ready, busy, done, masked_plaintext
  );
endinterface

// File: rtl/ipm_red_mask_seq.sv
// ipm_red_mask_seq: masks a 128-bit block one byte per fresh random word into redundant IPM shares (S, S^3)
module ipm_red_mask_seq #(parameter int v = 4) (
  input logic               clk,
  input logic               rst,
  ipm_red_mask_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MASK, DONE} state_t;
  state_t             state_q;
  logic [3:0]         cnt_q;
  logic [127:0]       pt_q;
  logic [8*(v-2)-1:0] l1_q;
  logic [8*(v-2)-1:0] l2_q;
  logic [128*v-1:0]   mp_q;
  logic               busy_q;
  logic               ready_q;
  logic               done_q;
  logic [7:0]         s;
  logic [7:0]         z0_d;
  logic [7:0]         z1_d;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // shares 0 and 1 of the current byte; shares 0/1 of L1/L2 are the fixed unit vectors, so only j>=2 enter the sums
  always_comb begin
    s = pt_q[{cnt_q, 3'b000} +: 8];
    z0_d = s;
    z1_d = gmul(gmul(s, s), s);
    for (int j = 0; j < v - 2; j++) begin
      z0_d = z0_d ^ gmul(l1_q[8*j +: 8], bus.rnd_in[8*j +: 8]);
      z1_d = z1_d ^ gmul(l2_q[8*j +: 8], bus.rnd_in[8*j +: 8]);
    end
  end
  // sequencer: capture on start, one byte per valid random word, one-cycle done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pt_q    <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
      mp_q    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          pt_q    <= bus.plaintext;
          l1_q    <= bus.L1[8*v-1:16];
          l2_q    <= bus.L2[8*v-1:16];
          cnt_q   <= '0;
          state_q <= MASK;
          busy_q  <= 1'b1;
          ready_q <= 1'b1;
        end
        MASK: if (bus.rnd_valid) begin
          mp_q[int'(cnt_q)*8*v +: 8*v] <= {bus.rnd_in, z1_d, z0_d};
          cnt_q <= (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy             = busy_q;
  assign bus.rnd_ready        = ready_q;
  assign bus.done             = done_q;
  assign bus.masked_plaintext = mp_q;
endmodule

// File: tb/tb_ipm_red_mask_seq.sv
// tb_ipm_red_mask_seq: directed and unmasking checks of the IPM masking sequencer at v=4
module tb_ipm_red_mask_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic [127:0] pt2;
  logic [127:0] pt_r;
  logic [511:0] exp2;
  logic [31:0]  w;
  logic [7:0]   sv;
  ipm_red_mask_seq_if #(.v(4)) bus();
  ipm_red_mask_seq #(.v(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) p = xt(p) ^ (b[i] ? a : 8'h00);
    return p;
  endfunction
  task automatic run_block(input logic [127:0] pt, input logic [15:0] rnd, input bit rnd_rand,
                           input int stall_at, input int stall_len, input int restart_at,
                           input int rst_at, input int mid_at, input logic [511:0] mid_exp,
                           output int lat_o);
    bus.plaintext = pt;
    bus.rnd_in = rnd;
    bus.rnd_valid = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat_o = 1;
    while (!bus.done && lat_o < 60) begin
      if (lat_o == rst_at) begin
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        lat_o = -1;
        break;
      end
      if (rnd_rand) bus.rnd_in = 16'($urandom);
      bus.rnd_valid = !(lat_o >= stall_at && lat_o < stall_at + stall_len);
      bus.start = (lat_o == restart_at);
      if (lat_o == restart_at) begin
        bus.plaintext = ~pt;
        bus.L1 = 32'hdeadbeef;
        bus.L2 = 32'h12345678;
      end
      if (lat_o == mid_at) chk("mid_partial", bus.masked_plaintext, mid_exp);
      if (!bus.rnd_valid) chk("stall_ready", 512'(bus.rnd_ready), 512'd1);
      tick();
      lat_o++;
    end
    bus.start = 1'b0;
    bus.rnd_valid = 1'b1;
    bus.L1 = 32'h03020001;
    bus.L2 = 32'h05040100;
    if (bus.done) begin
      chk("busy_in_done", 512'(bus.busy), 512'd0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("done_one_cycle", 512'(bus.done), 512'd0);
      chk("start_in_done_ignored", 512'(bus.busy), 512'd0);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.plaintext = '0;
    bus.L1 = 32'h03020001;
    bus.L2 = 32'h05040100;
    bus.rnd_in = '0;
    bus.rnd_valid = 1'b0;
    pt2 = 128'h0302;
    exp2 = 512'h00000f0300000802;
    tick();
    tick();
    chk("rst_busy", 512'(bus.busy), 512'd0);
    chk("rst_done", 512'(bus.done), 512'd0);
    chk("rst_ready", 512'(bus.rnd_ready), 512'd0);
    chk("rst_mp", bus.masked_plaintext, 512'd0);
    rst = 1'b0;
    tick();
    run_block(128'd0, 16'h0000, 1'b0, 0, 0, 0, 0, 0, '0, lat);
    chk("zero_lat", 512'(lat), 512'd17);
    chk("zero_mp", bus.masked_plaintext, 512'd0);
    run_block(pt2, 16'h0000, 1'b0, 0, 0, 0, 0, 0, '0, lat);
    chk("pt2_lat", 512'(lat), 512'd17);
    chk("pt2_mp", bus.masked_plaintext, exp2);
    bus.L1 = 32'h0302ffee;
    bus.L2 = 32'h0504ffee;
    run_block(128'd0, 16'h0101, 1'b0, 0, 0, 0, 0, 0, '0, lat);
    chk("ones_lat", 512'(lat), 512'd17);
    chk("ones_mp", bus.masked_plaintext, {64{8'h01}});
    tick();
    tick();
    chk("ones_hold", bus.masked_plaintext, {64{8'h01}});
    run_block(pt2, 16'h0000, 1'b0, 8, 5, 0, 0, 3, {{56{8'h01}}, 64'h00000f0300000802}, lat);
    chk("stall_lat", 512'(lat), 512'd22);
    chk("stall_mp", bus.masked_plaintext, exp2);
    run_block(128'hffff, 16'h0101, 1'b0, 0, 0, 0, 8, 0, '0, lat);
    chk("rst_abort_busy", 512'(bus.busy), 512'd0);
    chk("rst_abort_mp", bus.masked_plaintext, 512'd0);
    chk("rst_abort_done", 512'(bus.done), 512'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_done", 512'(bus.done | bus.busy), 512'd0);
    end
    run_block(pt2, 16'h0000, 1'b0, 0, 0, 3, 0, 0, '0, lat);
    chk("restart_lat", 512'(lat), 512'd17);
    chk("restart_mp", bus.masked_plaintext, exp2);
    pt_r = {$urandom, $urandom, $urandom, $urandom};
    run_block(pt_r, 16'h0000, 1'b1, 0, 0, 0, 0, 0, '0, lat);
    chk("rand_lat", 512'(lat), 512'd17);
    for (int k = 0; k < 16; k++) begin
      w = bus.masked_plaintext[32*k +: 32];
      sv = pt_r[8*k +: 8];
      chk("unmask_s", 512'(w[7:0] ^ gm(8'h02, w[23:16]) ^ gm(8'h03, w[31:24])), 512'(sv));
      chk("unmask_s3", 512'(w[15:8] ^ gm(8'h04, w[23:16]) ^ gm(8'h05, w[31:24])), 512'(gm(gm(sv, sv), sv)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
